fwd_pipe_unit: RTL and testbench

FWD_PIPE_UNIT -- requirements
Module: fwd_pipe_unit

---
 rtl/fwd_pipe_unit_if.sv | 34 +++
 rtl/fwd_pipe_unit.sv | 95 +++++++++
 tb/tb_fwd_pipe_unit.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fwd_pipe_unit_if.sv
// Decode-stage forwarding bus: operand requests and in-flight results in, forwarding decisions out.
interface fwd_pipe_unit_if #(
    parameter int DATA_W = 32,
    parameter int NRD    = 2,
    parameter int NSTG   = 3,
    parameter int AW     = 5
);
    localparam int SW = $clog2(NSTG + 1);

    logic                   d_valid;
    logic [NRD*AW-1:0]      d_rs;
    logic [NRD*2-1:0]       d_tuse;
    logic                   d_we;
    logic [AW-1:0]          d_rd;
    logic [1:0]             d_tnew;
    logic                   flush;
    logic [NSTG*DATA_W-1:0] stg_res;
    logic [NRD*DATA_W-1:0]  grf_rd;

    logic                   stall;
    logic [NRD*SW-1:0]      fwd_sel;
    logic [NRD*DATA_W-1:0]  opnd;
    logic [NRD-1:0]         opnd_rdy;

    modport master (
        output d_valid, d_rs, d_tuse, d_we, d_rd, d_tnew, flush, stg_res, grf_rd,
        input  stall, fwd_sel, opnd, opnd_rdy
    );

    modport slave (
        input  d_valid, d_rs, d_tuse, d_we, d_rd, d_tnew, flush, stg_res, grf_rd,
        output stall, fwd_sel, opnd, opnd_rdy
    );
endinterface

// File: rtl/fwd_pipe_unit.sv
// Operand forwarding and hazard stall unit tracking NSTG post-decode producers.
// Optional FWD_PERF_CNT_EN adds a saturating 32-bit stall_cnt output.
module fwd_pipe_unit #(
    parameter int DATA_W = 32,
    parameter int NRD    = 2,
    parameter int NSTG   = 3,
    parameter int AW     = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
`ifdef FWD_PERF_CNT_EN
    output logic [31:0]          stall_cnt,
`endif
    fwd_pipe_unit_if.slave       bus
);
    localparam int SW = $clog2(NSTG + 1);

    logic [NSTG-1:0] slot_v;
    logic [AW-1:0]   slot_rd [NSTG];
    logic [1:0]      slot_tn [NSTG];
    logic [NRD-1:0]  port_stall;
    logic            slot0_load;

    // Search runs oldest to youngest so the youngest matching producer overwrites older ones.
    always_comb begin
        logic [AW-1:0] rs;
        logic [1:0]    tuse;
        logic          hit;
        int            hit_k;
        bus.fwd_sel  = '0;
        bus.opnd     = bus.grf_rd;
        bus.opnd_rdy = '1;
        port_stall   = '0;
        rs           = '0;
        tuse         = '0;
        hit          = 1'b0;
        hit_k        = 0;
        for (int p = 0; p < NRD; p++) begin
            rs    = bus.d_rs[p*AW +: AW];
            tuse  = bus.d_tuse[p*2 +: 2];
            hit   = 1'b0;
            hit_k = 0;
            for (int k = NSTG - 1; k >= 0; k--) begin
                if (slot_v[k] && (slot_rd[k] == rs) && (rs != '0)) begin
                    hit   = 1'b1;
                    hit_k = k;
                end
            end
            if (hit) begin
                if (slot_tn[hit_k] == 2'd0) begin
                    bus.fwd_sel[p*SW +: SW]      = SW'(hit_k + 1);
                    bus.opnd[p*DATA_W +: DATA_W] = bus.stg_res[hit_k*DATA_W +: DATA_W];
                end else if (slot_tn[hit_k] <= tuse) begin
                    bus.opnd_rdy[p] = 1'b0;
                end else begin
                    bus.opnd_rdy[p] = 1'b0;
                    port_stall[p]   = 1'b1;
                end
            end
        end
    end

    assign bus.stall  = bus.d_valid & (|port_stall);
    assign slot0_load = bus.d_valid & bus.d_we & (bus.d_rd != '0) & ~bus.stall & ~bus.flush;

    // Older slots keep advancing during a stall; only slot 0 takes a bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NSTG; k++) begin
                slot_v[k]  <= 1'b0;
                slot_rd[k] <= '0;
                slot_tn[k] <= '0;
            end
        end else begin
            slot_v[0]  <= slot0_load;
            slot_rd[0] <= slot0_load ? bus.d_rd : '0;
            slot_tn[0] <= slot0_load ? bus.d_tnew : 2'd0;
            for (int k = 1; k < NSTG; k++) begin
                slot_v[k]  <= slot_v[k-1];
                slot_rd[k] <= slot_rd[k-1];
                slot_tn[k] <= (slot_tn[k-1] == 2'd0) ? 2'd0 : slot_tn[k-1] - 2'd1;
            end
        end
    end

`ifdef FWD_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (bus.stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fwd_pipe_unit.sv
// Bench for fwd_pipe_unit: directed hazard scenarios plus random traffic against a producer-age model.
module tb_fwd_pipe_unit;
    localparam int DATA_W = 32;
    localparam int NRD    = 2;
    localparam int NSTG   = 3;
    localparam int AW     = 5;
    localparam int SW     = $clog2(NSTG + 1);

    typedef struct {
        bit v;
        int rd;
        int tnew;
    } rec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int failures = 0;

    rec_t slots[$];
    bit   exp_stall;
    int   exp_sel [NRD];
    logic [DATA_W-1:0] exp_opnd [NRD];
    bit   exp_rdy [NRD];
    bit   port_st [NRD];
    logic [31:0] exp_cnt = 32'd0;

`ifdef FWD_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    fwd_pipe_unit_if #(.DATA_W(DATA_W), .NRD(NRD), .NSTG(NSTG), .AW(AW)) bus ();

    fwd_pipe_unit #(.DATA_W(DATA_W), .NRD(NRD), .NSTG(NSTG), .AW(AW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
`ifdef FWD_PERF_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .bus      (bus)
    );

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apply_stimulus(input bit v, input int rs0, input int rs1, input int tu0,
                                  input int tu1, input bit we, input int rd, input int tnew,
                                  input bit fl);
        bus.d_valid = v;
        bus.d_rs    = {AW'(rs1), AW'(rs0)};
        bus.d_tuse  = {2'(tu1), 2'(tu0)};
        bus.d_we    = we;
        bus.d_rd    = AW'(rd);
        bus.d_tnew  = 2'(tnew);
        bus.flush   = fl;
    endtask

    task automatic model_reset();
        slots.delete();
        for (int k = 0; k < NSTG; k++) slots.push_back(rec_t'{v: 1'b0, rd: 0, tnew: 0});
        exp_cnt = 32'd0;
    endtask

    // A producer k cycles past E has tn = max(tnew - k, 0).
    task automatic compute_expected();
        exp_stall = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            int rs;
            int tuse;
            int hit;
            int tn;
            rs   = int'(bus.d_rs[p*AW +: AW]);
            tuse = int'(bus.d_tuse[p*2 +: 2]);
            hit  = -1;
            exp_sel[p]  = 0;
            exp_opnd[p] = bus.grf_rd[p*DATA_W +: DATA_W];
            exp_rdy[p]  = 1'b1;
            port_st[p]  = 1'b0;
            if (rs != 0) begin
                for (int k = 0; k < NSTG; k++) begin
                    if (hit < 0 && slots[k].v && slots[k].rd == rs) hit = k;
                end
            end
            if (hit >= 0) begin
                tn = slots[hit].tnew - hit;
                if (tn < 0) tn = 0;
                if (tn == 0) begin
                    exp_sel[p]  = hit + 1;
                    exp_opnd[p] = bus.stg_res[hit*DATA_W +: DATA_W];
                end else if (tn <= tuse) begin
                    exp_rdy[p] = 1'b0;
                end else begin
                    port_st[p] = 1'b1;
                    if (bus.d_valid) exp_stall = 1'b1;
                end
            end
        end
    endtask

    task automatic eval_check(input string tag);
        #1;
        compute_expected();
        check_output({tag, ".stall"}, 64'(bus.stall), 64'(exp_stall));
        for (int p = 0; p < NRD; p++) begin
            if (!port_st[p]) begin
                check_output($sformatf("%s.sel%0d", tag, p), 64'(bus.fwd_sel[p*SW +: SW]), 64'(exp_sel[p]));
                check_output($sformatf("%s.rdy%0d", tag, p), 64'(bus.opnd_rdy[p]), 64'(exp_rdy[p]));
                if (exp_rdy[p])
                    check_output($sformatf("%s.opnd%0d", tag, p), 64'(bus.opnd[p*DATA_W +: DATA_W]), 64'(exp_opnd[p]));
            end
        end
`ifdef FWD_PERF_CNT_EN
        check_output({tag, ".cnt"}, 64'(stall_cnt), 64'(exp_cnt));
`endif
    endtask

    task automatic advance();
        bit load;
        compute_expected();
        @(posedge clk);
        if (reset_n) begin
            load = bus.d_valid && bus.d_we && (bus.d_rd != '0) && !exp_stall && !bus.flush;
            slots.push_front(rec_t'{v: load, rd: load ? int'(bus.d_rd) : 0, tnew: int'(bus.d_tnew)});
            void'(slots.pop_back());
            if (exp_stall && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
        end
        @(negedge clk);
    endtask

    task automatic randomize_data();
        for (int k = 0; k < NSTG; k++) bus.stg_res[k*DATA_W +: DATA_W] = $urandom;
        for (int p = 0; p < NRD; p++) bus.grf_rd[p*DATA_W +: DATA_W] = $urandom;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        model_reset();
        randomize_data();
        apply_stimulus(1'b1, 3, 5, 0, 0, 1'b0, 0, 0, 1'b0);
        bus.grf_rd = {32'h11, 32'h22};
        eval_check("reset");
        check_output("reset.opnd0", 64'(bus.opnd[0 +: DATA_W]), 64'h22);
        check_output("reset.opnd1", 64'(bus.opnd[DATA_W +: DATA_W]), 64'h11);
        check_output("reset.rdy", 64'(bus.opnd_rdy), 64'h3);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // tnew=0 producer forwarded from E.
        apply_stimulus(1'b1, 0, 0, 0, 0, 1'b1, 8, 0, 1'b0);
        eval_check("issue8");
        advance();
        apply_stimulus(1'b1, 8, 0, 0, 0, 1'b0, 0, 0, 1'b0);
        bus.stg_res[0 +: DATA_W] = 32'hAB;
        eval_check("fwdE");
        check_output("fwdE.sel0", 64'(bus.fwd_sel[0 +: SW]), 64'd1);
        check_output("fwdE.opnd0", 64'(bus.opnd[0 +: DATA_W]), 64'hAB);
        check_output("fwdE.stall", 64'(bus.stall), 64'd0);
        advance();

        // Load-use: two stall cycles, then forward from W.
        apply_stimulus(1'b1, 0, 0, 0, 0, 1'b1, 9, 2, 1'b0);
        eval_check("issue9");
        advance();
        apply_stimulus(1'b1, 0, 9, 0, 0, 1'b0, 0, 0, 1'b0);
        bus.stg_res[2*DATA_W +: DATA_W] = 32'h5A5A;
        eval_check("load1");
        check_output("load1.stall", 64'(bus.stall), 64'd1);
        advance();
        eval_check("load2");
        check_output("load2.stall", 64'(bus.stall), 64'd1);
        advance();
        eval_check("load3");
        check_output("load3.stall", 64'(bus.stall), 64'd0);
        check_output("load3.sel1", 64'(bus.fwd_sel[SW +: SW]), 64'd3);
        check_output("load3.opnd1", 64'(bus.opnd[DATA_W +: DATA_W]), 64'h5A5A);
        advance();

        // Two producers of r4; the youngest wins.
        apply_stimulus(1'b1, 0, 0, 0, 0, 1'b1, 4, 0, 1'b0);
        eval_check("issue4a");
        advance();
        eval_check("issue4b");
        advance();
        apply_stimulus(1'b1, 4, 0, 0, 0, 1'b0, 0, 0, 1'b0);
        bus.stg_res[0 +: DATA_W] = 32'h1111;
        bus.stg_res[DATA_W +: DATA_W] = 32'h2222;
        eval_check("young");
        check_output("young.sel0", 64'(bus.fwd_sel[0 +: SW]), 64'd1);
        check_output("young.opnd0", 64'(bus.opnd[0 +: DATA_W]), 64'h1111);
        advance();

        // r0 writes never create a record.
        apply_stimulus(1'b1, 0, 0, 0, 0, 1'b1, 0, 0, 1'b0);
        eval_check("issue0");
        advance();
        apply_stimulus(1'b1, 0, 0, 0, 0, 1'b0, 0, 0, 1'b0);
        bus.grf_rd[0 +: DATA_W] = 32'h77;
        eval_check("r0");
        check_output("r0.sel0", 64'(bus.fwd_sel[0 +: SW]), 64'd0);
        check_output("r0.opnd0", 64'(bus.opnd[0 +: DATA_W]), 64'h77);
        advance();

        // Reset asserted mid-stall drops stall immediately.
        apply_stimulus(1'b1, 0, 0, 0, 0, 1'b1, 9, 3, 1'b0);
        eval_check("issue9b");
        advance();
        apply_stimulus(1'b1, 9, 0, 0, 0, 1'b0, 0, 0, 1'b0);
        eval_check("midrst");
        check_output("midrst.stall_pre", 64'(bus.stall), 64'd1);
        #1 reset_n = 1'b0;
        #1;
        check_output("midrst.stall", 64'(bus.stall), 64'd0);
        check_output("midrst.rdy", 64'(bus.opnd_rdy), 64'h3);
        check_output("midrst.sel", 64'(bus.fwd_sel), 64'd0);
        check_output("midrst.opnd0", 64'(bus.opnd[0 +: DATA_W]), 64'(bus.grf_rd[0 +: DATA_W]));
`ifdef FWD_PERF_CNT_EN
        check_output("midrst.cnt", 64'(stall_cnt), 64'd0);
`endif
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;

        // Three stall cycles from a tnew=3 producer consumed with tuse=0.
        apply_stimulus(1'b1, 0, 0, 0, 0, 1'b1, 9, 3, 1'b0);
        eval_check("issue9c");
        advance();
        apply_stimulus(1'b1, 9, 0, 0, 0, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            eval_check("st3");
            check_output("st3.stall", 64'(bus.stall), 64'd1);
            advance();
        end
        eval_check("st3end");
        check_output("st3end.stall", 64'(bus.stall), 64'd0);
`ifdef FWD_PERF_CNT_EN
        check_output("st3end.cnt", 64'(stall_cnt), 64'd3);
`endif
        advance();

        for (int i = 0; i < 400; i++) begin
            apply_stimulus($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                           $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                           $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 7) == 0);
            randomize_data();
            eval_check("rand");
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
